// File: rtl/ddr2_line_bridge.sv
// ddr2_line_bridge
// Turns 32-bit word requests into single-beat 128-bit line commands on the
// DDR2 MIG user interface. A one-line read buffer lets reads that land in the
// line fetched last complete without stalling. Writes are write-through with
// per-word byte masks and also patch the buffer when they hit it.
//
// Ports
//   clock_i, resetn_i        system clock, asynchronous active-low reset
//   en_i, we_i, addr_i, wd_i word request (held stable while stall_o=1)
//   rd_o, stall_o            read data / combinational stall
//   init_calib_complete_i    MIG calibration done
//   app_*                    MIG command, write-data and read-data channels
//
// state      | meaning
// INIT       | waiting for MIG calibration, stall follows en
// IDLE       | serve buffer hits, latch misses and writes
// RD_CMD     | read command presented to MIG
// RD_WAIT    | waiting for read line, then refill buffer
// WR         | write command and data presented, tracked independently
// DONE       | one cycle with stall=0 to consume the held request
module ddr2_line_bridge #(
    parameter int ADDR_WIDTH = 27
) (
    input  logic                  clock_i,
    input  logic                  resetn_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wd_i,
    output logic [31:0]           rd_o,
    output logic                  stall_o,
    input  logic                  init_calib_complete_i,
    output logic [ADDR_WIDTH-1:0] app_addr_o,
    output logic [2:0]            app_cmd_o,
    output logic                  app_en_o,
    input  logic                  app_rdy_i,
    output logic [127:0]          app_wdf_data_o,
    output logic [15:0]           app_wdf_mask_o,
    output logic                  app_wdf_wren_o,
    output logic                  app_wdf_end_o,
    input  logic                  app_wdf_rdy_i,
    input  logic [127:0]          app_rd_data_i,
    input  logic                  app_rd_data_valid_i
);

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_RD_CMD  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_WR      = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    logic [2:0]   state_q, state_d;
    logic         buf_valid_q, buf_valid_d;
    logic [29:0]  buf_tag_q, buf_tag_d;
    logic [127:0] buf_line_q, buf_line_d;
    logic [29:0]  req_tag_q, req_tag_d;
    logic [1:0]   req_k_q, req_k_d;
    logic [31:0]  req_wd_q, req_wd_d;
    logic         cmd_ok_q, cmd_ok_d;
    logic         dat_ok_q, dat_ok_d;

    logic         hit;
    logic         req_hit;
    logic [31:0]  buf_word;
    logic         cmd_done;
    logic         dat_done;

    assign hit      = buf_valid_q && (buf_tag_q == addr_i[31:2]);
    assign req_hit  = buf_valid_q && (buf_tag_q == req_tag_q);
    // read data follows the live address, not the latched one
    assign buf_word = buf_line_q[{addr_i[1:0], 5'b00000} +: 32];

    // MIG address unit is 16 bits, so a 16-byte line spans 8 units
    assign app_addr_o     = {req_tag_q[ADDR_WIDTH-4:0], 3'b000};
    assign app_cmd_o      = (state_q == ST_WR) ? 3'b000 : 3'b001;
    assign app_en_o       = (state_q == ST_RD_CMD) || ((state_q == ST_WR) && !cmd_ok_q);
    assign app_wdf_wren_o = (state_q == ST_WR) && !dat_ok_q;
    assign app_wdf_end_o  = app_wdf_wren_o;
    assign app_wdf_data_o = {4{req_wd_q}};
    assign app_wdf_mask_o = ~(16'h000F << {req_k_q, 2'b00});

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_line_d  = buf_line_q;
        req_tag_d   = req_tag_q;
        req_k_d     = req_k_q;
        req_wd_d    = req_wd_q;
        cmd_ok_d    = cmd_ok_q;
        dat_ok_d    = dat_ok_q;
        cmd_done    = cmd_ok_q || app_rdy_i;
        dat_done    = dat_ok_q || app_wdf_rdy_i;
        stall_o     = 1'b0;
        rd_o        = 32'h0;

        case (state_q)
            ST_INIT: begin
                stall_o = en_i;
                if (init_calib_complete_i) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                rd_o = buf_word;
                if (en_i && (we_i || !hit)) begin
                    stall_o   = 1'b1;
                    req_tag_d = addr_i[31:2];
                    req_k_d   = addr_i[1:0];
                    req_wd_d  = wd_i;
                    cmd_ok_d  = 1'b0;
                    dat_ok_d  = 1'b0;
                    state_d   = we_i ? ST_WR : ST_RD_CMD;
                end
            end
            ST_RD_CMD: begin
                stall_o = 1'b1;
                if (app_rdy_i) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                stall_o = 1'b1;
                if (app_rd_data_valid_i) begin
                    buf_line_d  = app_rd_data_i;
                    buf_tag_d   = req_tag_q;
                    buf_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_WR: begin
                stall_o  = 1'b1;
                cmd_ok_d = cmd_done;
                dat_ok_d = dat_done;
                if (cmd_done && dat_done) begin
                    state_d = ST_DONE;
                    if (req_hit) buf_line_d[{req_k_q, 5'b00000} +: 32] = req_wd_q;
                end
            end
            ST_DONE: begin
                rd_o    = buf_word;
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= ST_INIT;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_line_q  <= '0;
            req_tag_q   <= '0;
            req_k_q     <= '0;
            req_wd_q    <= '0;
            cmd_ok_q    <= 1'b0;
            dat_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_line_q  <= buf_line_d;
            req_tag_q   <= req_tag_d;
            req_k_q     <= req_k_d;
            req_wd_q    <= req_wd_d;
            cmd_ok_q    <= cmd_ok_d;
            dat_ok_q    <= dat_ok_d;
        end
    end

endmodule

// File: doc/ddr2_line_bridge.md
Name: ddr2_line_bridge

Overview:
- Sits directly downstream of the board's ddr2_en/we/addr/wd/rd/stall word port.
- Converts 32-bit word requests into 128-bit line commands on the DDR2 MIG user (app_*) interface.
- Keeps a one-line read buffer so consecutive reads in the same 4-word line return with zero stall.
- Writes are write-through, issued with per-word byte masks.

Parameters:
- ADDR_WIDTH, 27, width of app_addr; MIG address unit is 16 bits, so one line = 8 units.

Ports:
- clock  in  1  system clock; MIG user interface clock domain.
- resetn  in  1  asynchronous active-low reset.
- en  in  1  word request valid.
- we  in  1  1 = write, 0 = read; qualified by en.
- addr  in  32  word address.
- wd  in  32  write data.
- rd  out  32  read data; valid when en=1, we=0, stall=0.
- stall  out  1  combinational; requester holds en/we/addr/wd stable while stall=1.
- init_calib_complete  in  1  MIG calibration done.
- app_addr  out  ADDR_WIDTH  line address.
- app_cmd  out  3  3'b001 read, 3'b000 write.
- app_en  out  1  command valid.
- app_rdy  in  1  command accepted when app_en & app_rdy.
- app_wdf_data  out  128  write line.
- app_wdf_mask  out  16  1 = byte NOT written.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  equals app_wdf_wren (single-beat burst).
- app_wdf_rdy  in  1  data accepted when app_wdf_wren & app_wdf_rdy.
- app_rd_data  in  128  read line.
- app_rd_data_valid  in  1  read line valid.

Behaviour:
- Reset: resetn is asynchronous and active-low; the block has one clock.
- On resetn=0, registers clear asynchronously: state=INIT, buf_valid=0, buf_tag=0, buf_line=0, app_en=0, app_wdf_wren=0, rd=0. stall is combinational (= en during INIT).
- Address mapping:
  - app_addr = {addr[ADDR_WIDTH-2:2], 3'b000}; addr bits above are ignored (alias).
  - Word select k = addr[1:0]; word k occupies data bits [32k+31:32k].
  - Mask is 16'hFFFF with bits [4k+3:4k] cleared.
  - Tag = addr[31:2].
- Hit = buf_valid & (buf_tag == addr[31:2]).
- States:
  - INIT: stall=en. Go to IDLE when init_calib_complete=1.
  - IDLE:
    - If en & ~we & hit: stall=0 and rd = buffer word k, same cycle. Stay in IDLE.
    - If en & (we | ~hit): stall=1. Latch the request; go to RD_CMD (read) or WR (write).
    - If en=0: stall=0.
  - RD_CMD: app_en=1, app_cmd=001, stall=1. On app_rdy, go to RD_WAIT.
  - RD_WAIT: stall=1. On app_rd_data_valid:
    - buf_line=app_rd_data, buf_tag=latched tag, buf_valid=1.
    - Go to DONE.
  - WR:
    - Drive app_en=1 (cmd 000) and app_wdf_wren=app_wdf_end=1.
    - app_wdf_data = wd replicated into all 4 words; mask as above.
    - Command and data handshakes are tracked independently with flags cmd_ok and dat_ok. Each signal deasserts once its own handshake completes; both may complete in the same cycle.
    - When both have completed, go to DONE.
    - If the write hits the buffer, buffer word k = wd; otherwise the buffer is untouched.
    - Write completion from MIG is not awaited.
  - DONE: stall=0 for exactly one cycle, consuming the held request; rd = buffer word k for reads. Go to IDLE next cycle.
- In DONE and IDLE, rd is registered-free: it is a mux of buf_line indexed by the current addr[1:0].
- app_rd_data_valid outside RD_WAIT is ignored.
- app_en and app_wdf_wren are never asserted in INIT, IDLE or DONE.
- Reset mid-operation aborts the transaction, invalidates the buffer and drops app_en/app_wdf_wren immediately.

Test Plan:
- Calibration: init_calib_complete=0, en=1, we=0, addr=5 for 10 cycles -> stall=1 and app_en=0 throughout. Raise calib -> app_en=1, app_addr=27'h8, app_cmd=1.
- Read miss: addr=5, MIG returns app_rd_data=128'h44444444_33333333_22222222_11111111 after app_rdy held low 2 cycles -> one-cycle DONE with stall=0, rd=32'h22222222.
- Read hit: directly after the miss above, addr=6 -> stall=0 in the same cycle, rd=32'h33333333, app_en stays 0. Then addr=9 -> miss, app_addr=27'h10.
- Write with backpressure: addr=7, wd=32'hDEADBEEF, app_rdy=1, app_wdf_rdy low 3 cycles:
  - app_en pulses 1 cycle; app_wdf_wren held 4 cycles.
  - app_wdf_mask=16'h0FFF; data[127:96]=DEADBEEF.
  - stall releases only after data is accepted.
  - A following read of addr=7 hits with rd=DEADBEEF.
- Write miss: addr=0x40, wd=1 while buffer holds line 1 -> buffer tag unchanged. A read of addr=5 still hits.
- Reset mid-read: assert resetn=0 during RD_WAIT, release, re-calibrate -> app_en=0 during reset. Read of addr=5 misses and issues a new command.
